// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - RV32M multiply/divide unit; MD_FAST_MUL_EN selects a single-cycle multiplier
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            valid_in,
    input  logic            is_md,
    input  logic [2:0]      md_op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            stall_in,
    output logic            stall_out,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic [31:0]     md_count,
    input  logic            md_count_reset
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REMU   = 3'b111;

    state_t          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d, result_q, result_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d, sign_a_q, sign_a_d;
    logic            result_valid_q, result_valid_d;
    logic [31:0]     md_count_q, md_count_d;

    logic            in_a_signed, in_b_signed, a_neg, b_neg, fast;
    logic [XLEN-1:0] a_mag, b_mag, fast_res;
    logic [XLEN:0]   mul_sum, trial;
    logic            div_ge;
    logic [XLEN-1:0] step_hi, step_lo, quo_fix, rem_fix, final_res;
    logic [2*XLEN-1:0] prod_fix;
`ifdef MD_FAST_MUL_EN
    logic signed [2*XLEN-1:0] fm_prod;
`endif

    // Decode incoming op: operand signedness, magnitudes and the single-cycle special cases
    always_comb begin
        in_a_signed = (md_op != OP_MULHU) && (md_op != OP_DIVU) && (md_op != OP_REMU);
        in_b_signed = in_a_signed && (md_op != OP_MULHSU);
        a_neg       = in_a_signed & rs1[XLEN-1];
        b_neg       = in_b_signed & rs2[XLEN-1];
        a_mag       = a_neg ? -rs1 : rs1;
        b_mag       = b_neg ? -rs2 : rs2;
        fast        = 1'b0;
        fast_res    = '0;
        if (md_op[2]) begin
            if (rs2 == '0) begin
                // divide by zero: quotient all ones, remainder is the dividend
                fast     = 1'b1;
                fast_res = md_op[1] ? rs1 : '1;
            end else if (!md_op[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1)) begin
                // signed overflow: quotient is the dividend, remainder zero
                fast     = 1'b1;
                fast_res = md_op[1] ? '0 : rs1;
            end
        end
`ifdef MD_FAST_MUL_EN
        fm_prod = $signed({in_a_signed & rs1[XLEN-1], rs1}) * $signed({in_b_signed & rs2[XLEN-1], rs2});
        if (!md_op[2]) begin
            fast     = 1'b1;
            fast_res = (md_op == OP_MUL) ? fm_prod[XLEN-1:0] : fm_prod[2*XLEN-1:XLEN];
        end
`endif
    end

    // One radix-2 step on the magnitudes plus the sign-corrected final result
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        trial   = {hi_q, lo_q[XLEN-1]};
        div_ge  = (trial >= {1'b0, opb_q});
        if (op_q[2]) begin
            // remainder after a successful subtract is below the divisor, so it fits in XLEN bits
            step_hi = div_ge ? (trial[XLEN-1:0] - opb_q) : trial[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], div_ge};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod_fix = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        quo_fix  = neg_q ? -step_lo : step_lo;
        rem_fix  = sign_a_q ? -step_hi : step_hi;
        case (op_q)
            OP_MUL:                      final_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             final_res = quo_fix;
            default:                     final_res = rem_fix;
        endcase
    end

    // FSM next state, operand capture, iteration and completion counting
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        opb_d      = opb_q;
        op_d       = op_q;
        neg_d      = neg_q;
        sign_a_d   = sign_a_q;
        result_d   = result_q;
        md_count_d = md_count_q;
        case (state_q)
            IDLE: begin
                if (valid_in && is_md && !flush) begin
                    op_d     = md_op;
                    sign_a_d = a_neg;
                    neg_d    = a_neg ^ b_neg;
                    hi_d     = '0;
                    lo_d     = a_mag;
                    opb_d    = b_mag;
                    cnt_d    = '0;
                    if (fast) begin
                        result_d = fast_res;
                        state_d  = DONE;
                    end else begin
                        state_d  = BUSY;
                    end
                end
            end
            BUSY: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    result_d = final_res;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (!stall_in) begin
                    state_d    = IDLE;
                    md_count_d = md_count_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d    = IDLE;
            md_count_d = md_count_q;
        end
        if (md_count_reset) begin
            md_count_d = '0;
        end
        result_valid_d = (state_d == DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            hi_q           <= '0;
            lo_q           <= '0;
            opb_q          <= '0;
            op_q           <= '0;
            neg_q          <= 1'b0;
            sign_a_q       <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            md_count_q     <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            hi_q           <= hi_d;
            lo_q           <= lo_d;
            opb_q          <= opb_d;
            op_q           <= op_d;
            neg_q          <= neg_d;
            sign_a_q       <= sign_a_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            md_count_q     <= md_count_d;
        end
    end

    assign stall_out    = valid_in & is_md & (state_q != DONE);
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign md_count     = md_count_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - directed self-checking bench for ex_muldiv (iterative multiply build)
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        reset, flush, valid_in, is_md, stall_in, md_count_reset;
    logic [2:0]  md_op;
    logic [31:0] rs1, rs2;
    logic        stall_out, result_valid;
    logic [31:0] result, md_count;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_count = 0;

    ex_muldiv #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in), .is_md(is_md),
        .md_op(md_op), .rs1(rs1), .rs2(rs2), .stall_in(stall_in), .stall_out(stall_out),
        .result(result), .result_valid(result_valid), .md_count(md_count),
        .md_count_reset(md_count_reset)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Issue one op, measure latency and stall, optionally hold in DONE, then retire it.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat_exp,
                          input int hold, input bit clr);
        int lat;
        int stall_cnt;
        @(negedge clk);
        md_op = op; rs1 = a; rs2 = b; valid_in = 1'b1; is_md = 1'b1;
        #1;
        check({tag, "_stall_acc"}, 32'(stall_out), 32'd1);
        stall_cnt = 1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        while (!result_valid && lat < 40) begin
            if (stall_out) stall_cnt++;
            rs1 = $urandom; rs2 = $urandom; md_op = 3'($urandom);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_lat"}, 32'(lat), 32'(lat_exp));
        check({tag, "_res"}, result, exp);
        check({tag, "_stall_done"}, 32'(stall_out), 32'd0);
        if (lat_exp == 33) check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'd33);
        for (int i = 0; i < hold; i++) begin
            stall_in = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_res"}, result, exp);
            check({tag, "_hold_rv"}, 32'(result_valid), 32'd1);
            check({tag, "_hold_cnt"}, md_count, 32'(exp_count));
        end
        stall_in = 1'b0; valid_in = 1'b0; md_count_reset = clr;
        @(posedge clk);
        @(negedge clk);
        md_count_reset = 1'b0;
        exp_count = clr ? 0 : exp_count + 1;
        check({tag, "_count"}, md_count, 32'(exp_count));
        check({tag, "_rv_low"}, 32'(result_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; valid_in = 1'b0; is_md = 1'b0; stall_in = 1'b0;
        md_count_reset = 1'b0; md_op = 3'd0; rs1 = '0; rs2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_result", result, 32'h0);
        check("rst_rv", 32'(result_valid), 32'd0);
        check("rst_count", md_count, 32'h0);
        check("rst_stall", 32'(stall_out), 32'd0);

        run_op("mul",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0, 1'b0);
        run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, 1'b0);
        run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 0, 1'b0);
        run_op("divu_z",  3'b101, 32'd100,      32'd0,        32'hFFFFFFFF, 1, 0, 1'b0);
        run_op("remu_z",  3'b111, 32'd100,      32'd0,        32'h00000064, 1, 0, 1'b0);
        run_op("div_neg", 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 0, 1'b0);
        run_op("rem_neg", 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 0, 1'b0);
        run_op("mulhu",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0, 1'b0);
        run_op("mulhsu",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 0, 1'b0);
        run_op("mulh",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 0, 1'b0);
        run_op("mul_big", 3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 33, 0, 1'b0);
        run_op("div_nd",  3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, 0, 1'b0);
        run_op("rem_nd",  3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 33, 0, 1'b0);
        run_op("remu",    3'b111, 32'd100,      32'd7,        32'h00000002, 33, 0, 1'b0);

        // flush while BUSY at iteration count 10
        @(negedge clk);
        md_op = 3'b101; rs1 = 32'd12345; rs2 = 32'd7; valid_in = 1'b1; is_md = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; valid_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush_rv", 32'(result_valid), 32'd0);
        check("flush_count", md_count, 32'(exp_count));
        run_op("divu_post", 3'b101, 32'd9, 32'd3, 32'd3, 33, 0, 1'b0);

        run_op("stall_hold", 3'b100, 32'd100, 32'd7, 32'd14, 33, 3, 1'b0);
        run_op("cnt_clr", 3'b101, 32'd100, 32'd0, 32'hFFFFFFFF, 1, 0, 1'b1);
        run_op("after_clr", 3'b111, 32'd5, 32'd0, 32'd5, 1, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
